// File: rtl/sd_cmd_tx.sv
// SD card CMD-line transmitter: serialises a 48-bit command frame with CRC7 and
// then optionally supervises the response window, timing out after 64 cycles.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | line released (out=1, oe=0); waiting for start
// SEND      | driving the 48 frame bits, one per clk, MSB first
// WAIT_RESP | receiver enabled; counting until a response starts or finishes
module sd_cmd_tx (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    input  logic        expect_resp,
    input  logic        resp_started,
    input  logic        resp_finished,
    output logic        sd_cmd_out,
    output logic        sd_cmd_oe,
    output logic        rx_en,
    output logic        busy,
    output logic        done,
    output logic        timeout
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [39:0] sr_q, sr_d;
    logic [6:0]  crc_q, crc_d;
    logic [6:0]  crc_next;
    logic        resp_q, resp_d;
    logic [6:0]  wait_cnt_q, wait_cnt_d;
    logic        seen_q, seen_d;
    logic        started;
    logic        out_q, out_d;
    logic        oe_q, oe_d;
    logic        rx_en_q, rx_en_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        timeout_q, timeout_d;

    // sr_q[39] is always the frame bit currently on the line during bits 0..39
    assign crc_next = {crc_q[5:0], 1'b0} ^ ((sr_q[39] ^ crc_q[6]) ? 7'h09 : 7'h00);
    assign started  = seen_q | resp_started;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        sr_d       = sr_q;
        crc_d      = crc_q;
        resp_d     = resp_q;
        wait_cnt_d = wait_cnt_q;
        seen_d     = seen_q;
        out_d      = out_q;
        oe_d       = oe_q;
        rx_en_d    = rx_en_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        timeout_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                out_d   = 1'b1;
                oe_d    = 1'b0;
                rx_en_d = 1'b0;
                busy_d  = 1'b0;
                if (start) begin
                    state_d    = SEND;
                    sr_d       = {2'b01, cmd_index, cmd_arg};
                    resp_d     = expect_resp;
                    bit_cnt_d  = 6'd0;
                    crc_d      = 7'd0;
                    wait_cnt_d = 7'd0;
                    seen_d     = 1'b0;
                    out_d      = 1'b0;
                    oe_d       = 1'b1;
                    busy_d     = 1'b1;
                end
            end

            SEND: begin
                bit_cnt_d = bit_cnt_q + 6'd1;
                sr_d      = {sr_q[38:0], 1'b0};
                if (bit_cnt_q < 6'd39) begin
                    crc_d = crc_next;
                    out_d = sr_q[38];
                end else if (bit_cnt_q == 6'd39) begin
                    out_d = crc_next[6];
                    crc_d = {crc_next[5:0], 1'b0};
                end else if (bit_cnt_q < 6'd46) begin
                    out_d = crc_q[6];
                    crc_d = {crc_q[5:0], 1'b0};
                end else if (bit_cnt_q == 6'd46) begin
                    out_d = 1'b1;
                end else begin
                    out_d      = 1'b1;
                    oe_d       = 1'b0;
                    bit_cnt_d  = 6'd0;
                    wait_cnt_d = 7'd0;
                    seen_d     = 1'b0;
                    if (resp_q) begin
                        state_d = WAIT_RESP;
                        rx_en_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end

            WAIT_RESP: begin
                // a finishing response wins over a simultaneous timeout
                if (resp_finished) begin
                    state_d = IDLE;
                    rx_en_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (!started && wait_cnt_q == 7'd63) begin
                    state_d    = IDLE;
                    wait_cnt_d = 7'd64;
                    rx_en_d    = 1'b0;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    timeout_d  = 1'b1;
                end else begin
                    seen_d = started;
                    if (!started)
                        wait_cnt_d = wait_cnt_q + 7'd1;
                end
            end

            default: begin
                state_d = IDLE;
                out_d   = 1'b1;
                oe_d    = 1'b0;
                rx_en_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 6'd0;
            sr_q       <= 40'd0;
            crc_q      <= 7'd0;
            resp_q     <= 1'b0;
            wait_cnt_q <= 7'd0;
            seen_q     <= 1'b0;
            out_q      <= 1'b1;
            oe_q       <= 1'b0;
            rx_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            sr_q       <= sr_d;
            crc_q      <= crc_d;
            resp_q     <= resp_d;
            wait_cnt_q <= wait_cnt_d;
            seen_q     <= seen_d;
            out_q      <= out_d;
            oe_q       <= oe_d;
            rx_en_q    <= rx_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
        end
    end

    assign sd_cmd_out = out_q;
    assign sd_cmd_oe  = oe_q;
    assign rx_en      = rx_en_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_sd_cmd_tx.sv
// Self-checking bench for sd_cmd_tx: table vectors, random commands against a
// frame/CRC and response-window model, plus reset and back-to-back sequences.
module tb_sd_cmd_tx;

    logic        clk = 1'b0;
    logic        reset, start, expect_resp, resp_started, resp_finished;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        sd_cmd_out, sd_cmd_oe, rx_en, busy, done, timeout;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [5:0]  idx;
        logic [31:0] arg;
        logic        er;
        int          s;
        int          f;
        logic [47:0] frame;
    } vec_t;

    vec_t tbl[7];

    sd_cmd_tx dut (
        .clk(clk), .reset(reset), .start(start), .cmd_index(cmd_index),
        .cmd_arg(cmd_arg), .expect_resp(expect_resp), .resp_started(resp_started),
        .resp_finished(resp_finished), .sd_cmd_out(sd_cmd_out), .sd_cmd_oe(sd_cmd_oe),
        .rx_en(rx_en), .busy(busy), .done(done), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Frame per the SD rule: 0,1,index,arg, CRC7 (x^7+x^3+1) over those 40 bits, 1
    function automatic logic [47:0] model_frame(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] d;
        logic [6:0]  c;
        logic        fb;
        d = {2'b01, idx, arg};
        c = 7'd0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return {d, c, 1'b1};
    endfunction

    // mode 0: start one cycle; 1: start/resp noise during SEND; 2: start held through done
    task automatic run_cmd(input vec_t v, input int mode, input string tag);
        logic [47:0] got;
        int oe_low, busy_low, early_done, rx_bad, k, exp_at;
        logic exp_to;
        got = '0; oe_low = 0; busy_low = 0; early_done = 0; rx_bad = 0;
        cmd_index = v.idx; cmd_arg = v.arg; expect_resp = v.er; start = 1'b1;
        @(negedge clk);
        if (mode != 2) start = 1'b0;
        for (int i = 0; i < 48; i++) begin
            got = {got[46:0], sd_cmd_out};
            if (!sd_cmd_oe) oe_low++;
            if (!busy) busy_low++;
            if (done) early_done++;
            cmd_index = 6'($urandom); cmd_arg = $urandom; expect_resp = 1'($urandom);
            if (mode == 1) begin
                start = 1'($urandom); resp_started = 1'($urandom); resp_finished = 1'($urandom);
            end
            @(negedge clk);
        end
        start = (mode == 2); resp_started = 1'b0; resp_finished = 1'b0;
        chk({tag, " frame"}, 64'(got), 64'(v.frame));
        chk({tag, " oe_low_in_send"}, 64'(oe_low), 64'd0);
        chk({tag, " busy_low_in_send"}, 64'(busy_low), 64'd0);
        chk({tag, " done_in_send"}, 64'(early_done), 64'd0);
        if (!v.er) begin
            chk({tag, " end {out,oe,rx,busy,done,to}"},
                64'({sd_cmd_out, sd_cmd_oe, rx_en, busy, done, timeout}), 64'b100010);
        end else begin
            chk({tag, " wait entry {out,oe,rx,busy}"},
                64'({sd_cmd_out, sd_cmd_oe, rx_en, busy}), 64'b1011);
            k = 0;
            while (!done && k <= 200) begin
                if (!rx_en || !busy) rx_bad++;
                resp_started  = (k == v.s);
                resp_finished = (k == v.f);
                @(negedge clk);
                k++;
            end
            resp_started = 1'b0; resp_finished = 1'b0;
            exp_to = (v.s > 63) && (v.f > 63);
            exp_at = exp_to ? 64 : v.f + 1;
            chk({tag, " done_cycle"}, 64'(k), 64'(exp_at));
            chk({tag, " timeout"}, 64'(timeout), 64'(exp_to));
            chk({tag, " end {rx,busy,oe}"}, 64'({rx_en, busy, sd_cmd_oe}), 64'b000);
            chk({tag, " rx_en_dropped_early"}, 64'(rx_bad), 64'd0);
        end
        if (mode != 2) begin
            @(negedge clk);
            chk({tag, " post {done,to,busy}"}, 64'({done, timeout, busy}), 64'b000);
        end
    endtask

    initial begin
        int dcount;
        vec_t v;
        reset = 1'b1; start = 1'b0; expect_resp = 1'b0; resp_started = 1'b0;
        resp_finished = 1'b0; cmd_index = '0; cmd_arg = '0;
        #2;
        chk("reset {out,oe,rx,busy,done,to}",
            64'({sd_cmd_out, sd_cmd_oe, rx_en, busy, done, timeout}), 64'b100000);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        tbl[0] = '{6'd0,  32'h0,     1'b0, 0,    0,    48'h400000000095};
        tbl[1] = '{6'd8,  32'h1AA,   1'b1, 10,   140,  48'h48000001AA87};
        tbl[2] = '{6'd17, 32'h0,     1'b1, 1000, 1000, 48'h510000000055};
        tbl[3] = '{6'd17, 32'h0,     1'b1, 1000, 63,   48'h510000000055};
        tbl[4] = '{6'd17, 32'h0,     1'b1, 63,   150,  48'h510000000055};
        tbl[5] = '{6'd8,  32'h1AA,   1'b1, 64,   1000, 48'h48000001AA87};
        tbl[6] = '{6'd0,  32'h0,     1'b1, 1000, 0,    48'h400000000095};
        foreach (tbl[i]) run_cmd(tbl[i], 0, $sformatf("vec%0d", i));

        // start and response noise during SEND must not disturb the frame
        run_cmd(tbl[1], 1, "noisy_send");

        // start held high: second command begins straight out of the done cycle
        run_cmd(tbl[0], 2, "b2b_first");
        run_cmd(tbl[1], 0, "b2b_second");

        for (int r = 0; r < 10; r++) begin
            v.idx = 6'($urandom); v.arg = $urandom; v.er = 1'($urandom);
            v.s = int'($urandom_range(0, 90)); v.f = int'($urandom_range(0, 150));
            v.frame = model_frame(v.idx, v.arg);
            run_cmd(v, int'($urandom_range(0, 1)), $sformatf("rnd%0d", r));
        end

        // reset at bit 20 of SEND
        cmd_index = 6'd17; cmd_arg = 32'h0; expect_resp = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20; i++) @(negedge clk);
        #1 reset = 1'b1;
        #1 chk("send_abort {out,oe,rx,busy,done,to}",
               64'({sd_cmd_out, sd_cmd_oe, rx_en, busy, done, timeout}), 64'b100000);
        dcount = 0;
        for (int i = 0; i < 3; i++) begin @(negedge clk); if (done) dcount++; end
        reset = 1'b0;
        for (int i = 0; i < 60; i++) begin @(negedge clk); if (done || busy) dcount++; end
        chk("send_abort no_done", 64'(dcount), 64'd0);
        run_cmd(tbl[0], 0, "after_abort");

        // reset inside WAIT_RESP
        cmd_index = 6'd17; cmd_arg = 32'h0; expect_resp = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 53; i++) @(negedge clk);
        chk("wait_before_reset rx_en", 64'(rx_en), 64'd1);
        #1 reset = 1'b1;
        #1 chk("wait_abort {out,oe,rx,busy,done,to}",
               64'({sd_cmd_out, sd_cmd_oe, rx_en, busy, done, timeout}), 64'b100000);
        @(negedge clk);
        reset = 1'b0;
        dcount = 0;
        for (int i = 0; i < 80; i++) begin @(negedge clk); if (done || timeout) dcount++; end
        chk("wait_abort no_done", 64'(dcount), 64'd0);
        run_cmd(tbl[2], 0, "after_wait_abort");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/sd_cmd_tx.md
SD_CMD_TX -- requirements
Module: sd_cmd_tx

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all state changes on rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous, active-high; forces reset state immediately.
REQ-003 SHALL have port start, input, 1, request to issue one command; sampled only in IDLE.
REQ-004 SHALL have port cmd_index, input, 6, command index; latched on accepted start.
REQ-005 SHALL have port cmd_arg, input, 32, command argument; latched on accepted start.
REQ-006 SHALL have port expect_resp, input, 1, response expected after command; latched on accepted start.
REQ-007 SHALL have port resp_started, input, 1, downstream response receiver has detected a start bit.
REQ-008 SHALL have port resp_finished, input, 1, downstream response receiver has captured a full response.
REQ-009 SHALL have port sd_cmd_out, output, 1, CMD line drive value.
REQ-010 SHALL have port sd_cmd_oe, output, 1, CMD line output enable; 1 = drive sd_cmd_out.
REQ-011 SHALL have port rx_en, output, 1, enable to the downstream response receiver.
REQ-012 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-013 SHALL have port done, output, 1, one-cycle pulse at end of transaction.
REQ-014 SHALL have port timeout, output, 1, one-cycle pulse, coincident with done, when no response starts in time.

Function
REQ-015 SHALL implement states IDLE, SEND, WAIT_RESP; all outputs registered.
REQ-016 IDLE: sd_cmd_out=1, sd_cmd_oe=0, rx_en=0, busy=0; on start=1, latch inputs and enter SEND.
REQ-017 SHALL ignore start while busy=1; latched fields do not change mid-transaction.
REQ-018 SHALL frame 48 bits MSB first: start 0, transmission 1, cmd_index[5:0], cmd_arg[31:0], CRC7[6:0], end 1.
REQ-019 SEND: one bit per clk, sd_cmd_oe=1 for exactly 48 consecutive cycles; first bit (0) visible the cycle after start is sampled.
REQ-020 CRC7 SHALL use polynomial x^7+x^3+1, initial 0, computed serially over the first 40 frame bits, then shifted out MSB first.
REQ-021 After end bit with expect_resp=0: return to IDLE, done=1 for one cycle, sd_cmd_oe=0 the same cycle.
REQ-022 After end bit with expect_resp=1: enter WAIT_RESP, sd_cmd_oe=0, rx_en=1, 7-bit wait counter cleared.
REQ-023 WAIT_RESP: counter increments each cycle until resp_started=1; once resp_started seen, counter frozen and no timeout possible.
REQ-024 WAIT_RESP: resp_finished=1 -> rx_en=0, done=1 one cycle, IDLE next.
REQ-025 WAIT_RESP: counter reaches 64 with no resp_started -> rx_en=0, done=1 and timeout=1 one cycle, IDLE next.
REQ-026 resp_started and resp_finished SHALL be ignored outside WAIT_RESP; resp_finished same cycle as counter=64 takes priority (no timeout).
REQ-027 start may be accepted in the IDLE cycle right after done; back-to-back commands separated by exactly one IDLE cycle.

Reset
REQ-028 reset SHALL force IDLE, sd_cmd_out=1, sd_cmd_oe=0, rx_en=0, busy=0, done=0, timeout=0, counters and CRC cleared, asynchronously.
REQ-029 reset asserted mid-SEND or mid-WAIT_RESP SHALL abort the transaction with no done pulse; line released immediately.

Verification
REQ-030 CMD0, arg 0x00000000, expect_resp=0 -> 48-bit serial 0x400000000095, then done pulse, timeout=0.
REQ-031 CMD8, arg 0x000001AA, expect_resp=1 -> serial 0x48000001AA87; rx_en=1 after end bit; resp_started at +10, resp_finished at +140 -> done, no timeout.
REQ-032 CMD17, arg 0, expect_resp=1, resp_started never asserted -> frame 0x510000000055; done=timeout=1 64 cycles after rx_en rises.
REQ-033 start pulsed repeatedly during SEND -> frame unchanged, exactly one done; start held high through done -> second command begins after one IDLE cycle.
REQ-034 reset asserted at bit 20 of SEND -> sd_cmd_oe=0, sd_cmd_out=1 same cycle, busy=0, no done; next start sends full correct frame.
